// File: rtl/cpu_types_pkg.sv
// Shared CPU types for the data cache: address split, frame layout and controller states.
package cpu_types_pkg;

  localparam int TAG_W = 26;
  localparam int IDX_W = 3;

  localparam logic [31:0] HITCOUNT_ADDR = 32'h0000_3100;

  typedef logic [31:0] word_t;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [IDX_W-1:0] idx;
    logic             blkoff;
    logic [1:0]       bytoff;
  } dcachef_t;

  typedef struct packed {
    logic             valid;
    logic             dirty;
    logic [TAG_W-1:0] tag;
    word_t [1:0]      data;
  } dcache_frame_t;

  typedef enum logic [3:0] {
    IDLE,
    WB0,
    WB1,
    LD0,
    LD1,
    FLUSH0,
    FLUSH1,
    CNT,
    DONE
  } dcache_state_t;

endpackage

// File: rtl/dcache_set.sv
// Storage for one cache set: two frames (valid, dirty, tag, two words) and the LRU victim bit.
module dcache_set
  import cpu_types_pkg::*;
(
  input  logic             CLK,
  input  logic             nRST,
  input  logic             wr_en,
  input  logic             wr_way,
  input  logic             wr_off,
  input  word_t            wr_data,
  input  logic             dirty_en,
  input  logic             fill_en,
  input  logic [TAG_W-1:0] fill_tag,
  input  logic             lru_en,
  input  logic             lru_val,
  output dcache_frame_t    frame0,
  output dcache_frame_t    frame1,
  output logic             lru
);

  logic [1:0]       valid;
  logic [1:0]       dirty;
  logic [TAG_W-1:0] tag  [2];
  word_t [1:0]      data [2];

  // Control bits are reset; fill completion wins over a store marking the frame dirty.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      valid <= '0;
      dirty <= '0;
      lru   <= 1'b0;
    end else begin
      if (fill_en) begin
        valid[wr_way] <= 1'b1;
        dirty[wr_way] <= 1'b0;
      end else if (dirty_en) begin
        dirty[wr_way] <= 1'b1;
      end
      if (lru_en) begin
        lru <= lru_val;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (wr_en) begin
      data[wr_way][wr_off] <= wr_data;
    end
    if (fill_en) begin
      tag[wr_way] <= fill_tag;
    end
  end

  assign frame0 = {valid[0], dirty[0], tag[0], data[0]};
  assign frame1 = {valid[1], dirty[1], tag[1], data[1]};

endmodule

// File: rtl/dcache.sv
// 2-way set-associative write-back, write-allocate data cache with LRU and flush on halt.
// Defining DCACHE_HITCOUNT_EN adds a hit counter that is stored to HITCOUNT_ADDR after the flush.
module dcache
  import cpu_types_pkg::*;
#(
  parameter int SETS  = 8,
  parameter int WORDS = 2
)(
  input  logic        CLK,
  input  logic        nRST,
  input  logic        dmemREN,
  input  logic        dmemWEN,
  input  logic [31:0] dmemaddr,
  input  logic [31:0] dmemstore,
  input  logic        halt,
  output logic        dhit,
  output logic [31:0] dmemload,
  output logic        flushed,
  output logic        dREN,
  output logic        dWEN,
  output logic [31:0] daddr,
  output logic [31:0] dstore,
  input  logic [31:0] dload,
  input  logic        dwait
);

  localparam logic LAST_OFF = 1'(WORDS - 1);

  dcache_state_t state, next_state;

  dcachef_t         a;
  logic             req;
  logic [IDX_W:0]   cnt;
  logic             cnt_inc;
  logic             flush_last;
  logic [TAG_W-1:0] m_tag;
  logic [IDX_W-1:0] m_idx;
  logic             vway;
  logic             miss_go;

  dcache_frame_t    frm0  [SETS];
  dcache_frame_t    frm1  [SETS];
  logic             lru_q [SETS];

  logic [IDX_W-1:0] rd_idx;
  logic [IDX_W-1:0] wr_idx;
  logic             rd_way;
  dcache_frame_t    f0, f1, sf, vf;
  logic             lru_r;
  logic             hit0, hit1, hit, hway, vic;

  logic             wr_en, wr_way, wr_off;
  word_t            wr_data;
  logic             dirty_en, fill_en, lru_en, lru_val;

  logic             unused_bytoff;

  assign a             = dmemaddr;
  assign req           = dmemREN | dmemWEN;
  assign unused_bytoff = ^a.bytoff;
  assign flush_last    = &cnt;

`ifdef DCACHE_HITCOUNT_EN
  localparam dcache_state_t FLUSH_END = CNT;
  word_t hitcnt;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      hitcnt <= '0;
    end else if (dhit) begin
      hitcnt <= hitcnt + 32'd1;
    end else if (miss_go) begin
      hitcnt <= hitcnt - 32'd1;
    end
  end
`else
  localparam dcache_state_t FLUSH_END = DONE;
`endif

  for (genvar i = 0; i < SETS; i++) begin : g_set
    logic sel;
    assign sel = (wr_idx == IDX_W'(i));

    dcache_set u_set (
      .CLK      (CLK),
      .nRST     (nRST),
      .wr_en    (wr_en & sel),
      .wr_way   (wr_way),
      .wr_off   (wr_off),
      .wr_data  (wr_data),
      .dirty_en (dirty_en & sel),
      .fill_en  (fill_en & sel),
      .fill_tag (m_tag),
      .lru_en   (lru_en & sel),
      .lru_val  (lru_val),
      .frame0   (frm0[i]),
      .frame1   (frm1[i]),
      .lru      (lru_q[i])
    );
  end

  // IDLE looks up the requested set, the flush walks {way, set}, miss states use the latched set.
  always_comb begin
    rd_idx = m_idx;
    rd_way = vway;
    case (state)
      IDLE: rd_idx = a.idx;
      FLUSH0, FLUSH1: begin
        rd_idx = cnt[IDX_W-1:0];
        rd_way = cnt[IDX_W];
      end
      default: ;
    endcase
  end

  assign wr_idx = (state == IDLE) ? a.idx : m_idx;
  assign f0     = frm0[rd_idx];
  assign f1     = frm1[rd_idx];
  assign lru_r  = lru_q[rd_idx];
  assign sf     = rd_way ? f1 : f0;

  assign hit0 = f0.valid && (f0.tag == a.tag);
  assign hit1 = f1.valid && (f1.tag == a.tag);
  assign hit  = hit0 | hit1;
  assign hway = ~hit0;
  assign vic  = !f0.valid ? 1'b0 : (!f1.valid ? 1'b1 : lru_r);
  assign vf   = vic ? f1 : f0;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= next_state;
      if (cnt_inc) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // The miss context is held so the fill finishes even if the datapath drops its request.
  always_ff @(posedge CLK) begin
    if (miss_go) begin
      m_tag <= a.tag;
      m_idx <= a.idx;
      vway  <= vic;
    end
  end

  always_comb begin
    next_state = state;
    dhit       = 1'b0;
    dmemload   = '0;
    flushed    = 1'b0;
    dREN       = 1'b0;
    dWEN       = 1'b0;
    daddr      = '0;
    dstore     = '0;
    wr_en      = 1'b0;
    wr_way     = 1'b0;
    wr_off     = 1'b0;
    wr_data    = '0;
    dirty_en   = 1'b0;
    fill_en    = 1'b0;
    lru_en     = 1'b0;
    lru_val    = 1'b0;
    miss_go    = 1'b0;
    cnt_inc    = 1'b0;

    case (state)
      IDLE: begin
        if (req && hit) begin
          dhit    = 1'b1;
          lru_en  = 1'b1;
          lru_val = ~hway;
          if (dmemREN) begin
            dmemload = hway ? f1.data[a.blkoff] : f0.data[a.blkoff];
          end
          if (dmemWEN) begin
            wr_en    = 1'b1;
            wr_way   = hway;
            wr_off   = a.blkoff;
            wr_data  = dmemstore;
            dirty_en = 1'b1;
          end
        end
        // A pending miss is serviced before a halt is allowed to start the flush.
        if (req && !hit) begin
          miss_go    = 1'b1;
          next_state = (vf.valid && vf.dirty) ? WB0 : LD0;
        end else if (halt) begin
          next_state = FLUSH0;
        end
      end

      WB0, WB1: begin
        wr_off = (state == WB1) ? LAST_OFF : 1'b0;
        dWEN   = 1'b1;
        daddr  = {sf.tag, m_idx, wr_off, 2'b00};
        dstore = sf.data[wr_off];
        if (!dwait) begin
          next_state = (state == WB0) ? WB1 : LD0;
        end
        wr_off = 1'b0;
      end

      LD0, LD1: begin
        dREN  = 1'b1;
        daddr = {m_tag, m_idx, (state == LD1) ? LAST_OFF : 1'b0, 2'b00};
        if (!dwait) begin
          wr_en   = 1'b1;
          wr_way  = vway;
          wr_off  = (state == LD1) ? LAST_OFF : 1'b0;
          wr_data = dload;
          if (state == LD1) begin
            fill_en    = 1'b1;
            next_state = IDLE;
          end else begin
            next_state = LD1;
          end
        end
      end

      FLUSH0: begin
        if (sf.valid && sf.dirty) begin
          dWEN   = 1'b1;
          daddr  = {sf.tag, cnt[IDX_W-1:0], 1'b0, 2'b00};
          dstore = sf.data[0];
          if (!dwait) begin
            next_state = FLUSH1;
          end
        end else begin
          cnt_inc = 1'b1;
          if (flush_last) begin
            next_state = FLUSH_END;
          end
        end
      end

      FLUSH1: begin
        dWEN   = 1'b1;
        daddr  = {sf.tag, cnt[IDX_W-1:0], LAST_OFF, 2'b00};
        dstore = sf.data[LAST_OFF];
        if (!dwait) begin
          cnt_inc    = 1'b1;
          next_state = flush_last ? FLUSH_END : FLUSH0;
        end
      end

`ifdef DCACHE_HITCOUNT_EN
      CNT: begin
        dWEN   = 1'b1;
        daddr  = HITCOUNT_ADDR;
        dstore = hitcnt;
        if (!dwait) begin
          next_state = DONE;
        end
      end
`endif

      DONE: begin
        flushed = 1'b1;
      end

      default: next_state = IDLE;
    endcase
  end

endmodule

// File: tb/tb_dcache.sv
// Directed bench for dcache: a functional cache model predicts memory traffic, load data and latency.
`timescale 1ns/1ps
module tb_dcache;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        dmemREN, dmemWEN, halt;
  logic [31:0] dmemaddr, dmemstore;
  logic        dhit, flushed, dREN, dWEN, dwait;
  logic [31:0] dmemload, daddr, dstore, dload;

  dcache dut (
    .CLK(CLK), .nRST(nRST), .dmemREN(dmemREN), .dmemWEN(dmemWEN),
    .dmemaddr(dmemaddr), .dmemstore(dmemstore), .halt(halt),
    .dhit(dhit), .dmemload(dmemload), .flushed(flushed),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dload(dload), .dwait(dwait)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [31:0] data;
  } txn_t;

  int   errors = 0;
  int   checks = 0;
  txn_t exp_q[$];
  txn_t act_log[$];

  // Memory responder: L cycles per word, dwait high for the first L-1.
  logic [31:0] mem     [4096];
  logic [31:0] ref_mem [4096];
  int          lat;
  int          busy, busy_n;
  bit          pend, pend_we;
  logic [31:0] pend_addr, pend_data;

  assign dwait = (dREN || dWEN) && (busy < lat - 1);
  assign dload = mem[daddr[13:2]];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  always @(posedge CLK) begin
    if (!nRST) begin
      busy <= 0;
    end else begin
      if (pend && pend_we) mem[pend_addr[13:2]] <= pend_data;
      busy <= busy_n;
    end
    pend = 1'b0;
  end

  // Compare process: every completing transaction is matched against the model's queue.
  bit          stall_prev = 1'b0;
  logic [65:0] prev_req;
  always @(negedge CLK) begin
    if (nRST) begin
      check1("rw_exclusive", dREN & dWEN, 1'b0);
      check1("hit_only_idle", dhit & (dREN | dWEN), 1'b0);
      if (stall_prev)
        check1("stable_under_dwait", ({dREN, dWEN, daddr, dstore} == prev_req), 1'b1);
      if ((dREN || dWEN) && !dwait) begin
        pend      = 1'b1;
        pend_we   = dWEN;
        pend_addr = daddr;
        pend_data = dstore;
        act_log.push_back('{dWEN, daddr, dstore});
        check1("txn_expected", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) begin
          txn_t e;
          e = exp_q.pop_front();
          check1("txn_dir", dWEN, e.we);
          check("txn_addr", daddr, e.addr);
          if (e.we) check("txn_data", dstore, e.data);
        end
      end
      busy_n     = ((dREN || dWEN) && dwait) ? busy + 1 : 0;
      stall_prev = (dREN || dWEN) && dwait;
      prev_req   = {dREN, dWEN, daddr, dstore};
    end else begin
      busy_n     = 0;
      stall_prev = 1'b0;
    end
  end

  // Functional cache model.
  bit          m_valid [8][2];
  bit          m_dirty [8][2];
  logic [25:0] m_tag   [8][2];
  logic [31:0] m_data  [8][2][2];
  bit          m_lru   [8];
  int          n_acc, n_miss;

  task automatic model_reset();
    for (int s = 0; s < 8; s++) begin
      m_lru[s] = 1'b0;
      for (int w = 0; w < 2; w++) begin
        m_valid[s][w] = 1'b0;
        m_dirty[s][w] = 1'b0;
      end
    end
    n_acc  = 0;
    n_miss = 0;
  endtask

  task automatic model_access(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                              output logic [31:0] rdata, output int ntr);
    int          s, o, w;
    logic [25:0] t;
    logic [31:0] ba;
    s = int'(addr[5:3]);
    t = addr[31:6];
    o = int'(addr[2]);
    w = -1;
    ntr = 0;
    for (int i = 0; i < 2; i++)
      if (m_valid[s][i] && m_tag[s][i] == t) w = i;
    if (w < 0) begin
      if (!m_valid[s][0]) w = 0;
      else if (!m_valid[s][1]) w = 1;
      else w = int'(m_lru[s]);
      if (m_valid[s][w] && m_dirty[s][w]) begin
        for (int k = 0; k < 2; k++) begin
          ba = {m_tag[s][w], 3'(s), 1'(k), 2'b00};
          exp_q.push_back('{1'b1, ba, m_data[s][w][k]});
          ref_mem[ba[13:2]] = m_data[s][w][k];
          ntr++;
        end
      end
      for (int k = 0; k < 2; k++) begin
        ba = {t, 3'(s), 1'(k), 2'b00};
        exp_q.push_back('{1'b0, ba, 32'h0});
        m_data[s][w][k] = ref_mem[ba[13:2]];
        ntr++;
      end
      m_valid[s][w] = 1'b1;
      m_dirty[s][w] = 1'b0;
      m_tag[s][w]   = t;
      n_miss++;
    end
    rdata = m_data[s][w][o];
    if (we) begin
      m_data[s][w][o] = wdata;
      m_dirty[s][w]   = 1'b1;
    end
    m_lru[s] = (w == 0);
    n_acc++;
  endtask

  task automatic model_flush();
    int s, w;
    for (int c = 0; c < 16; c++) begin
      w = c >> 3;
      s = c & 7;
      if (m_valid[s][w] && m_dirty[s][w])
        for (int k = 0; k < 2; k++)
          exp_q.push_back('{1'b1, {m_tag[s][w], 3'(s), 1'(k), 2'b00}, m_data[s][w][k]});
    end
`ifdef DCACHE_HITCOUNT_EN
    exp_q.push_back('{1'b1, 32'h0000_3100, 32'(n_acc - n_miss)});
`endif
  endtask

  // One datapath request: drive, wait bounded for dhit, check data and latency.
  task automatic access(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                        output logic [31:0] got);
    logic [31:0] exp_rd;
    int          ntr, cyc, exp_lat;
    model_access(we, addr, wdata, exp_rd, ntr);
    exp_lat = (ntr == 0) ? 0 : 1 + ntr * lat;
    @(negedge CLK);
    dmemREN   = !we;
    dmemWEN   = we;
    dmemaddr  = addr;
    dmemstore = wdata;
    cyc = 0;
    #1;
    while (!dhit && cyc < 200) begin
      @(negedge CLK);
      #1;
      cyc++;
    end
    got = dmemload;
    check1($sformatf("dhit_%h", addr), dhit, 1'b1);
    if (!we) check($sformatf("load_%h", addr), dmemload, exp_rd);
    check($sformatf("latency_%h", addr), cyc, exp_lat);
    @(posedge CLK);
    #1;
    dmemREN = 1'b0;
    dmemWEN = 1'b0;
  endtask

  logic [31:0] got, exp_rd;
  int          n0, nt, cyc, nwr;
  bit          found;

  initial begin
    for (int i = 0; i < 4096; i++) begin
      mem[i]     = 32'hA000_0000 | 32'(i);
      ref_mem[i] = 32'hA000_0000 | 32'(i);
    end
    model_reset();
    lat = 2; busy = 0; busy_n = 0; pend = 1'b0;
    dmemREN = 0; dmemWEN = 0; dmemaddr = 0; dmemstore = 0; halt = 0;
    nRST = 1'b0;
    repeat (2) @(negedge CLK);
    #1;
    check1("rst_dhit", dhit, 1'b0);
    check("rst_dmemload", dmemload, 32'h0);
    check1("rst_flushed", flushed, 1'b0);
    check1("rst_dREN", dREN, 1'b0);
    check1("rst_dWEN", dWEN, 1'b0);
    check("rst_daddr", daddr, 32'h0);
    check("rst_dstore", dstore, 32'h0);
    @(negedge CLK);
    nRST = 1'b1;

    // Clean miss fill of 0x40 with L=2.
    access(1'b0, 32'h40, 32'h0, got);
    check("t1_load_literal", got, 32'hA000_0010);
    check("t1_txn_count", act_log.size(), 32'd2);
    if (act_log.size() == 2) begin
      check("t1_ld0_addr", act_log[0].addr, 32'h40);
      check("t1_ld1_addr", act_log[1].addr, 32'h44);
    end

    // Store hit and load hit, no memory traffic.
    n0 = act_log.size();
    access(1'b1, 32'h40, 32'hDEAD_BEEF, got);
    access(1'b0, 32'h44, 32'h0, got);
    check("t2_load_literal", got, 32'hA000_0011);
    check("t2_no_traffic", act_log.size(), n0);

    // Dirty eviction in set 0.
    access(1'b0, 32'h80, 32'h0, got);
    n0 = act_log.size();
    access(1'b0, 32'hC0, 32'h0, got);
    check("t3_txn_count", act_log.size(), n0 + 4);
    if (act_log.size() == n0 + 4) begin
      check("t3_wb_addr", act_log[n0].addr, 32'h40);
      check("t3_wb_data", act_log[n0].data, 32'hDEAD_BEEF);
      check("t3_ld_addr", act_log[n0 + 2].addr, 32'hC0);
    end

    // LRU: in set 1, the way not touched last is evicted.
    access(1'b0, 32'h48, 32'h0, got);
    access(1'b1, 32'h88, 32'h1234_5678, got);
    access(1'b0, 32'h48, 32'h0, got);
    n0 = act_log.size();
    access(1'b0, 32'hC8, 32'h0, got);
    check("t4_txn_count", act_log.size(), n0 + 4);
    if (act_log.size() == n0 + 4) begin
      check("t4_evict_addr", act_log[n0].addr, 32'h88);
      check("t4_evict_data", act_log[n0].data, 32'h1234_5678);
    end
    n0 = act_log.size();
    access(1'b0, 32'h48, 32'h0, got);
    check("t4_keep_literal", got, 32'hA000_0012);
    check("t4_keep_no_traffic", act_log.size(), n0);

    // Reset during LD1 with L=3.
    lat = 3;
    model_access(1'b0, 32'h100, 32'h0, exp_rd, nt);
    @(negedge CLK);
    dmemREN  = 1'b1;
    dmemaddr = 32'h100;
    found = 1'b0;
    cyc = 0;
    while (!found && cyc < 100) begin
      @(negedge CLK);
      #1;
      cyc++;
      if (dREN && daddr == 32'h104 && dwait) found = 1'b1;
    end
    check1("t5_reach_ld1", found, 1'b1);
    nRST = 1'b0;
    #1;
    check1("t5_dhit", dhit, 1'b0);
    check("t5_dmemload", dmemload, 32'h0);
    check1("t5_dREN", dREN, 1'b0);
    check1("t5_dWEN", dWEN, 1'b0);
    check("t5_daddr", daddr, 32'h0);
    check("t5_dstore", dstore, 32'h0);
    dmemREN = 1'b0;
    model_reset();
    exp_q.delete();
    @(negedge CLK);
    @(negedge CLK);
    nRST = 1'b1;
    #1;
    check1("t5_flushed", flushed, 1'b0);
    access(1'b0, 32'h100, 32'h0, got);
    check("t5_refill_literal", got, 32'hA000_0040);

    // Three dirty frames, then halt.
    lat = 2;
    access(1'b1, 32'h40, 32'h1111_1111, got);
    access(1'b1, 32'h50, 32'h2222_2222, got);
    access(1'b1, 32'h80, 32'h3333_3333, got);
    model_flush();
    n0 = act_log.size();
    @(negedge CLK);
    halt = 1'b1;
    cyc = 0;
    #1;
    while (!flushed && cyc < 500) begin
      @(negedge CLK);
      #1;
      cyc++;
    end
    check1("t6_flushed", flushed, 1'b1);
    nwr = 0;
    for (int i = n0; i < act_log.size(); i++)
      if (act_log[i].we) nwr++;
`ifdef DCACHE_HITCOUNT_EN
    check("t6_write_count", nwr, 32'd7);
`else
    check("t6_write_count", nwr, 32'd6);
`endif
    check("t6_all_expected_seen", exp_q.size(), 32'd0);

    // Requests in DONE are ignored.
    n0 = act_log.size();
    @(negedge CLK);
    dmemREN  = 1'b1;
    dmemaddr = 32'h50;
    for (int i = 0; i < 3; i++) begin
      #1;
      check1("t7_no_hit_in_done", dhit, 1'b0);
      @(negedge CLK);
    end
    dmemREN = 1'b0;
    check1("t7_flushed_sticky", flushed, 1'b1);
    check("t7_no_traffic", act_log.size(), n0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dcache.md
# dcache

Data-side cache that responds to the pipeline's data requests on the datapath–cache interface (dmemREN/dmemWEN/dmemaddr/dmemstore in; dhit/dmemload out) and initiates word transactions to the memory controller. It is a 2-way set-associative, write-back, write-allocate cache with LRU replacement. On halt it writes back every dirty block and then raises flushed.

## Interface
Parameters:
- SETS, 8: number of sets (power of 2).
- WORDS, 2: words per block; fixed at 2.

Ports:
- CLK  in  1  clock.
- nRST  in  1  async active-low reset.
- dmemREN  in  1  datapath read request.
- dmemWEN  in  1  datapath write request (never asserted together with dmemREN).
- dmemaddr  in  32  byte address, word aligned.
- dmemstore  in  32  store data.
- halt  in  1  datapath halt; starts the flush.
- dhit  out  1  request satisfied this cycle.
- dmemload  out  32  read data, valid when dhit.
- flushed  out  1  flush complete; sticky until reset.
- dREN  out  1  memory read.
- dWEN  out  1  memory write.
- daddr  out  32  memory word address.
- dstore  out  32  memory write data.
- dload  in  32  memory read data.
- dwait  in  1  memory busy; a transaction completes in the cycle dwait is low.

## Operation
- Address split: tag [31:6], index [5:3], block offset [2], byte offset [1:0] = 00.
- Each frame holds valid, dirty, tag and 2 words. Each set has one LRU bit naming the victim way.
- States: IDLE, WB0, WB1, LD0, LD1, FLUSH0, FLUSH1, CNT, DONE.
- IDLE:
  - Hit on dmemREN: dhit=1 and dmemload = the word, combinationally.
  - Hit on dmemWEN: dhit=1. At the clock edge the word is written and the dirty bit is set.
  - On any hit, the set's LRU bit is updated at the edge to point at the other way.
- IDLE miss:
  - Victim = the invalid way if one exists, otherwise the LRU way.
  - Victim valid and dirty → WB0. Otherwise → LD0.
- WB0/WB1: dWEN=1, daddr = {victim tag, index, offset, 00}, dstore = the victim word. Advance when !dwait. WB1 → LD0.
- LD0/LD1: dREN=1, daddr = {request tag, index, offset, 00}. Capture dload into the frame when !dwait.
- LD1 exit: set valid, clear dirty, write the tag, return to IDLE. The request then hits on the next cycle.
- Halt in IDLE with no pending miss → FLUSH0. Halt in any other state is held off until that state returns to IDLE.
- FLUSH0/FLUSH1:
  - A 4-bit counter walks {way, set}.
  - Dirty frames write both words back, using the same dWEN/daddr rules as the WB states.
  - Clean or invalid frames are skipped in one cycle.
- After the last frame → CNT if enabled (see Configuration), otherwise → DONE.
- DONE: flushed=1 and no memory requests. The state is left only on reset.
- No dhit is issued outside IDLE. Requests arriving in DONE are ignored.

## Timing
- Reset values: all valid, dirty and LRU bits 0; counter 0; state IDLE; dhit, dmemload, flushed, dREN, dWEN, daddr, dstore all 0.
- Reset asserted mid-transaction abandons it immediately. No partial writeback is retried.
- Hit latency: 0 cycles (same cycle as the request).
- Clean miss: 2 memory transactions, then 1 cycle for the hit.
- Dirty miss: 4 memory transactions, then 1 cycle for the hit.
- With memory latency L cycles per word (dwait high L−1 cycles), a clean miss takes 2L+1 cycles.
- dREN/dWEN, daddr and dstore stay constant while dwait is high.
- dREN and dWEN are never both asserted.
- The request signals are sampled every IDLE cycle. If the datapath drops a request during a miss, the fill still completes.

## Configuration
- DCACHE_HITCOUNT_EN defined:
  - A 32-bit counter increments on each dhit and decrements on each miss entry to WB0 or LD0.
  - State CNT writes the count to daddr 0x00003100 with dWEN, waiting for !dwait, before DONE.
- Not defined: no counter, no CNT state; the flush goes directly to DONE.

## Structure
- cpu_types_pkg gains:
  - dcachef_t: the address split (tag/idx/blkoff/bytoff).
  - dcache_frame_t: the frame fields.
  - dcache_state_t: the state enum.
  - Constant HITCOUNT_ADDR = 32'h3100.
- One sub-module, dcache_set: storage for a single set (two frames plus LRU). Instantiated SETS times.

## Test plan
- Read 0x40 after reset with L=2 → LD0 then LD1 (daddr 0x40, 0x44); the following cycle dhit=1 and dmemload = memory[0x40].
- Write 0xDEADBEEF to 0x40 after the fill, then read 0x44 → both hit with 0 latency; the frame is dirty; no memory traffic.
- Fill 0x40 (dirty), 0x80 and 0xC0 (same set 0) → the 0xC0 miss writes back 0x40/0x44 (dstore 0xDEADBEEF), then loads 0xC0/0xC4.
- Access 0x40 then 0x80, touch 0x40 again, then miss 0xC0 → the 0x80 way is evicted (LRU check).
- Assert halt with 3 dirty frames → exactly 6 dWEN transactions, then flushed=1. With DCACHE_HITCOUNT_EN, a 7th write of the count goes to 0x3100.
- Deassert nRST during LD1 → all outputs return to 0, a read of the same address misses again, and flushed stays 0.
